// File: rtl/processor_pin_entrada.sv
// -----------------------------------------------------------------------------
// processor_pin_entrada
//
// Avalon-MM slave input PIO, the read-side counterpart of the processor's
// output pin port. External pins are brought into the clk domain through a
// synchronizer, presented in a data register, edge-detected into a per-bit
// sticky edge-capture register and combined with a mask into a level irq.
//
// Parameters
//   WIDTH        number of input pins (1..32)
//   SYNC_STAGES  synchronizer flops per pin (>= 2)
//   EDGE_TYPE    capture edge: 0 = rising, 1 = falling, 2 = any
//   DEB_CYCLES   stable-cycle count for the debouncer (>= 2), only used when
//                PIN_ENTRADA_DEBOUNCE_EN is defined
//
// Optional feature
//   `define PIN_ENTRADA_DEBOUNCE_EN adds a per-bit debounce filter between the
//   synchronizer and the data register. Without it the synchronized pins are
//   used directly.
//
// Ports
//   clk         in   1      system clock
//   reset       in   1      asynchronous active-high reset
//   address     in   2      word address (0 data, 1 reserved, 2 irq_mask,
//                           3 edge_capture)
//   chipselect  in   1      slave select
//   write_n     in   1      active-low write strobe
//   writedata   in   32     write data (bits above WIDTH-1 ignored)
//   in_port     in   WIDTH  external pins, asynchronous to clk
//   readdata    out  32     read data, registered, read latency 1
//   irq         out  1      level interrupt, active-high
// -----------------------------------------------------------------------------
module processor_pin_entrada #(
  parameter int WIDTH       = 3,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0,
  parameter int DEB_CYCLES  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  // Register map
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  // Edge selection encodings
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Reject illegal configurations at elaboration time.
  if (WIDTH < 1 || WIDTH > 32 || SYNC_STAGES < 2 ||
      EDGE_TYPE < 0 || EDGE_TYPE > 2 || DEB_CYCLES < 2) begin : g_bad_param
    $error("processor_pin_entrada: illegal parameter combination");
  end

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic wr_en;
  assign wr_en = chipselect & ~write_n;

  // Upper writedata bits are architecturally ignored.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  // ---------------------------------------------------------------------------
  // Synchronizer
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] synced;

  // NOTE: the synchronizer array is a handful of flops, not a RAM, and its
  // contents are visible through the data register, so every stage is reset;
  // a RAM-style array would normally be left unreset.
  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the pre-edge value of its predecessor; blocking assignments here
  // would collapse the chain into a single flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Sampled value (optionally debounced)
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] sampled;

`ifdef PIN_ENTRADA_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [WIDTH-1:0] sampled_q;
  logic [CNT_W-1:0] deb_cnt_q [WIDTH];

  // A bit follows the synchronized pin only once the pin has disagreed with it
  // for DEB_CYCLES consecutive cycles; any cycle of agreement restarts the
  // count, so shorter glitches never propagate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sampled_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        deb_cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (synced[i] == sampled_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == CNT_LAST) begin
          deb_cnt_q[i] <= '0;
          sampled_q[i] <= synced[i];
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign sampled = sampled_q;
`else
  assign sampled = synced;
`endif

  // ---------------------------------------------------------------------------
  // Edge detection and capture
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] edge_clr;
  logic [WIDTH-1:0] edge_capture_q;
  logic [WIDTH-1:0] edge_capture_d;
  logic [WIDTH-1:0] irq_mask_q;

  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    edge_hit = '0;
    case (EDGE_TYPE)
      EDGE_RISE: edge_hit = sampled & ~prev_q;
      EDGE_FALL: edge_hit = ~sampled & prev_q;
      EDGE_ANY:  edge_hit = sampled ^ prev_q;
      default:   edge_hit = sampled & ~prev_q;
    endcase
  end

  assign edge_clr = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

  // Set is applied after clear so an edge arriving on the same cycle as a
  // software clear of that bit is kept rather than lost.
  assign edge_capture_d = (edge_capture_q & ~edge_clr) | edge_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q         <= '0;
      edge_capture_q <= '0;
      irq_mask_q     <= '0;
    end else begin
      prev_q         <= sampled;
      edge_capture_q <= edge_capture_d;
      if (wr_en && address == ADDR_MASK) begin
        irq_mask_q <= writedata[WIDTH-1:0];
      end
    end
  end

  // Level interrupt straight from registers: rises with the capture bit and
  // drops as soon as either the capture bit or its mask bit is cleared.
  assign irq = |(edge_capture_q & irq_mask_q);

  // ---------------------------------------------------------------------------
  // Read path: registered every cycle regardless of chipselect/write_n
  // ---------------------------------------------------------------------------
  logic [31:0] readdata_d;
  logic [31:0] readdata_q;

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA: readdata_d = 32'(sampled);
      ADDR_RSVD: readdata_d = '0;
      ADDR_MASK: readdata_d = 32'(irq_mask_q);
      ADDR_EDGE: readdata_d = 32'(edge_capture_q);
      default:   readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata_q <= '0;
    end else begin
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;

endmodule

// File: tb/tb_processor_pin_entrada.sv
// -----------------------------------------------------------------------------
// tb_processor_pin_entrada
//
// Directed, table-driven bench for processor_pin_entrada. Two instances share
// the bus and pins: u_dut captures rising edges, u_any captures any edge.
// Inputs are driven and outputs sampled 1 ns after the rising clk edge.
// Expected values are hand-computed from the register-level behaviour.
// -----------------------------------------------------------------------------
module tb_processor_pin_entrada;

  localparam int W = 3;

  logic        clk;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [W-1:0] in_port;
  logic [31:0] readdata;
  logic        irq;
  logic [31:0] readdata_any;
  logic        irq_any;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  processor_pin_entrada #(
    .WIDTH(W), .SYNC_STAGES(2), .EDGE_TYPE(0), .DEB_CYCLES(16)
  ) u_dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  processor_pin_entrada #(
    .WIDTH(W), .SYNC_STAGES(2), .EDGE_TYPE(2), .DEB_CYCLES(16)
  ) u_any (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata_any), .irq(irq_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] pins;
    logic [1:0]   addr;
    logic         wr;
    logic [31:0]  wdata;
    logic [31:0]  exp_rd;
    logic         exp_irq;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d,
                          output logic [31:0] d_any);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    tick();
    chipselect = 1'b0;
    d          = readdata;
    d_any      = readdata_any;
  endtask

  vec_t vecs [21];
  logic [31:0] rd, rd_any;

  initial begin
    reset      = 1'b1;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = '0;
    ticks(3);
    reset = 1'b0;

    // Reset state of all four registers and the interrupt.
    check("reset_irq", 32'(irq), 32'd0);
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), rd, rd_any);
      check($sformatf("reset_read_a%0d", a), rd, 32'd0);
    end

`ifndef PIN_ENTRADA_DEBOUNCE_EN
    // Per-cycle vectors: drive, clock once, then compare readdata and irq.
    //          pins    addr  wr    wdata          exp_rd  exp_irq
    vecs[0]  = '{3'b101, 2'd0, 1'b0, 32'h0,         32'd0, 1'b0};
    vecs[1]  = '{3'b101, 2'd0, 1'b0, 32'h0,         32'd0, 1'b0};
    vecs[2]  = '{3'b101, 2'd0, 1'b0, 32'h0,         32'd5, 1'b0};
    vecs[3]  = '{3'b101, 2'd3, 1'b0, 32'h0,         32'd5, 1'b0};
    vecs[4]  = '{3'b101, 2'd2, 1'b1, 32'h4,         32'd0, 1'b1};
    vecs[5]  = '{3'b101, 2'd2, 1'b0, 32'h0,         32'd4, 1'b1};
    vecs[6]  = '{3'b101, 2'd3, 1'b1, 32'h4,         32'd5, 1'b0};
    vecs[7]  = '{3'b101, 2'd3, 1'b0, 32'h0,         32'd1, 1'b0};
    vecs[8]  = '{3'b101, 2'd1, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b0};
    vecs[9]  = '{3'b101, 2'd2, 1'b0, 32'h0,         32'd4, 1'b0};
    vecs[10] = '{3'b101, 2'd3, 1'b0, 32'h0,         32'd1, 1'b0};
    vecs[11] = '{3'b101, 2'd2, 1'b1, 32'hFFFF_FFFB, 32'd4, 1'b1};
    vecs[12] = '{3'b101, 2'd2, 1'b0, 32'h0,         32'd3, 1'b1};
    vecs[13] = '{3'b101, 2'd2, 1'b1, 32'h0,         32'd3, 1'b0};
    vecs[14] = '{3'b101, 2'd3, 1'b0, 32'h0,         32'd1, 1'b0};
    vecs[15] = '{3'b101, 2'd3, 1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0};
    vecs[16] = '{3'b101, 2'd3, 1'b0, 32'h0,         32'd0, 1'b0};
    vecs[17] = '{3'b100, 2'd0, 1'b0, 32'h0,         32'd5, 1'b0};
    vecs[18] = '{3'b100, 2'd0, 1'b0, 32'h0,         32'd5, 1'b0};
    vecs[19] = '{3'b100, 2'd0, 1'b0, 32'h0,         32'd4, 1'b0};
    vecs[20] = '{3'b100, 2'd3, 1'b0, 32'h0,         32'd0, 1'b0};

    for (int i = 0; i < 21; i++) begin
      in_port    = vecs[i].pins;
      address    = vecs[i].addr;
      chipselect = vecs[i].wr;
      write_n    = ~vecs[i].wr;
      writedata  = vecs[i].wdata;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      check($sformatf("vec%0d_readdata", i), readdata, vecs[i].exp_rd);
      check($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].exp_irq));
    end

    // Set wins: first capture bit0, then clear it on the very edge where a
    // fresh bit0 rising edge is detected.
    in_port = 3'b101;
    ticks(3);
    bus_read(2'd3, rd, rd_any);
    check("setwin_pre_capture", rd, 32'd1);
    in_port = 3'b100;
    ticks(3);
    in_port = 3'b101;
    ticks(2);                 // rise now visible to edge detect
    bus_write(2'd3, 32'h1);   // clear collides with set
    bus_read(2'd3, rd, rd_any);
    check("setwin_bit0_kept", rd, 32'd1);
    bus_write(2'd3, 32'h1);   // clear with no competing edge
    bus_read(2'd3, rd, rd_any);
    check("clear_no_edge", rd, 32'd0);

    // Any-edge instance: bit1 0->1 then 1->0, clearing between.
    bus_write(2'd3, 32'h7);
    bus_read(2'd3, rd, rd_any);
    check("any_cleared", rd_any, 32'd0);
    in_port = 3'b111;
    ticks(3);
    bus_read(2'd3, rd, rd_any);
    check("any_rise_bit1", rd_any, 32'd2);
    check("rise_rise_bit1", rd, 32'd2);
    bus_write(2'd3, 32'h7);
    bus_read(2'd3, rd, rd_any);
    check("any_cleared2", rd_any, 32'd0);
    in_port = 3'b101;
    ticks(3);
    bus_read(2'd3, rd, rd_any);
    check("any_fall_bit1", rd_any, 32'd2);
    check("rise_ignores_fall", rd, 32'd0);

    // Reset mid-operation with an irq pending.
    bus_write(2'd2, 32'h7);
    check("any_irq_pending", 32'(irq_any), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("midreset_irq_drop", 32'(irq_any), 32'd0);
    check("midreset_readdata", readdata_any, 32'd0);
    ticks(2);
    reset = 1'b0;

    // Pins 101 already high at release: one capture after SYNC_STAGES+1.
    address = 2'd3;
    ticks(3);
    check("release_cap_not_yet", readdata, 32'd0);
    tick();
    check("release_cap_set", readdata, 32'd5);
    check("release_irq_masked", 32'(irq), 32'd0);
`else
    // Debounce: a 10-cycle pulse on bit2 is filtered out.
    in_port = 3'b100;
    ticks(10);
    in_port = 3'b000;
    ticks(30);
    bus_read(2'd0, rd, rd_any);
    check("deb_pulse_data", rd, 32'd0);
    bus_read(2'd3, rd, rd_any);
    check("deb_pulse_capture", rd, 32'd0);

    // A long high appears 2+16 cycles later, capture one cycle after that.
    address = 2'd0;
    in_port = 3'b100;
    ticks(18);
    check("deb_data_not_yet", readdata, 32'd0);
    tick();
    check("deb_data_set", readdata, 32'd4);
    address = 2'd3;
    tick();
    check("deb_capture_set", readdata, 32'd4);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
